// File: rtl/round_robin_encoder.sv
// Round-robin 4-to-2 request encoder.
// Registered grant index with valid/ready handshake.
module round_robin_encoder (
  input  logic clk,
  input  logic reset,
  input  logic in0,
  input  logic in1,
  input  logic in2,
  input  logic in3,
  input  logic enable,
  input  logic ready,
  output logic address0,
  output logic address1,
  output logic valid,
  output logic multi
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t     r_state;
  logic [1:0] r_last;
  logic [1:0] r_addr;
  logic       r_multi;
  logic       r_valid;

  logic [3:0] w_req;
  logic       w_any;
  logic       w_multi;
  logic [1:0] w_ptr;
  logic [1:0] w_win;
  logic       w_found;
  logic       w_load;

  assign w_req   = {in3, in2, in1, in0};
  assign w_any   = |w_req;
  assign w_multi = ($countones(w_req) > 1);
  assign w_load  = enable && w_any;

  // A handshake moves the pointer to the accepted index in the
  // same edge, so the back-to-back search starts after it.
  assign w_ptr = (r_state == HOLD) ? r_addr : r_last;

  // First high request at ptr+1, ptr+2, ptr+3, ptr (mod 4).
  always_comb begin : sel
    logic [1:0] v_idx;
    w_win   = '0;
    w_found = 1'b0;
    v_idx   = '0;
    for (int i = 0; i < 4; i++) begin
      v_idx = w_ptr + 2'(i + 1);
      if (!w_found && w_req[v_idx]) begin
        w_win   = v_idx;
        w_found = 1'b1;
      end
    end
  end

  // Grant FSM: select in IDLE, freeze in HOLD until accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= 2'd3;
      r_addr  <= 2'd0;
      r_multi <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_load) begin
            r_addr  <= w_win;
            r_multi <= w_multi;
            r_valid <= 1'b1;
            r_state <= HOLD;
          end else begin
            r_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (ready) begin
            r_last <= r_addr;
            if (w_load) begin
              r_addr  <= w_win;
              r_multi <= w_multi;
              r_valid <= 1'b1;
            end else begin
              r_valid <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign address0 = r_addr[0];
  assign address1 = r_addr[1];
  assign valid    = r_valid;
  assign multi    = r_multi;

endmodule

// File: tb/tb_round_robin_encoder.sv
// Directed bench for round_robin_encoder.
// Expected {valid,addr,multi} queued per edge, popped after it.
module tb_round_robin_encoder;

  logic clk;
  logic reset;
  logic in0, in1, in2, in3;
  logic enable;
  logic ready;
  logic address0, address1;
  logic valid;
  logic multi;

  int total;
  int bad;

  logic [3:0] q[$];

  round_robin_encoder dut (
    .clk      (clk),
    .reset    (reset),
    .in0      (in0),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .enable   (enable),
    .ready    (ready),
    .address0 (address0),
    .address1 (address1),
    .valid    (valid),
    .multi    (multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input logic r, input logic en,
                       input logic rdy, input logic [3:0] req);
    reset  = r;
    enable = en;
    ready  = rdy;
    {in3, in2, in1, in0} = req;
  endtask

  // exp = {valid, address1, address0, multi}
  task automatic tick(input string tag, input logic [3:0] exp);
    logic [3:0] want;
    logic [3:0] got;
    q.push_back(exp);
    @(posedge clk);
    #1;
    want = q.pop_front();
    got  = {valid, address1, address0, multi};
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, want);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    drive(1'b1, 1'b1, 1'b0, 4'b1111);

    tick("rst_edge1", 4'b0000);
    tick("rst_edge2", 4'b0000);
    drive(1'b0, 1'b1, 1'b0, 4'b1111);
    tick("first_grant", 4'b1001);

    drive(1'b0, 1'b1, 1'b1, 4'b1111);
    tick("rot_01", 4'b1011);
    tick("rot_10", 4'b1101);
    tick("rot_11", 4'b1111);
    tick("rot_00", 4'b1001);
    tick("rot_01b", 4'b1011);

    drive(1'b0, 1'b1, 1'b1, 4'b1010);
    tick("fair_11", 4'b1111);
    tick("fair_01", 4'b1011);

    drive(1'b0, 1'b1, 1'b1, 4'b0000);
    tick("drain_idle", 4'b0011);

    drive(1'b0, 1'b1, 1'b0, 4'b0100);
    tick("single_10", 4'b1100);
    tick("single_hold1", 4'b1100);
    tick("single_hold2", 4'b1100);
    drive(1'b0, 1'b1, 1'b0, 4'b0101);
    tick("single_hold3", 4'b1100);
    drive(1'b0, 1'b0, 1'b0, 4'b1011);
    tick("single_hold4", 4'b1100);
    drive(1'b0, 1'b1, 1'b0, 4'b0100);
    tick("single_hold5", 4'b1100);
    drive(1'b0, 1'b1, 1'b1, 4'b0000);
    tick("single_accept", 4'b0100);

    drive(1'b0, 1'b0, 1'b1, 4'b0010);
    tick("en_off1", 4'b0100);
    drive(1'b0, 1'b0, 1'b0, 4'b0010);
    tick("en_off2", 4'b0100);
    drive(1'b0, 1'b1, 1'b0, 4'b0010);
    tick("en_grant", 4'b1010);
    drive(1'b0, 1'b0, 1'b0, 4'b0000);
    tick("en_hold1", 4'b1010);
    tick("en_hold2", 4'b1010);
    tick("en_hold3", 4'b1010);

    drive(1'b0, 1'b1, 1'b1, 4'b0100);
    tick("pre_rst_10", 4'b1100);
    drive(1'b1, 1'b1, 1'b1, 4'b0100);
    tick("rst_mid", 4'b0000);
    drive(1'b0, 1'b1, 1'b0, 4'b1001);
    tick("rst_ptr", 4'b1001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
